// File: rtl/hash_mode_ctrl.sv
// hash_mode_ctrl: issue gate and subsample-mode sequencer in front of the
// hash/jitter stage. Samples are issued against downstream buffer credits.
// The jitter mask only changes after every in-flight sample has left the
// hash pipeline.
module hash_mode_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int CREDITS    = 4,
  parameter int CRED_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       samp_valid_in,
  output logic       samp_ready_out,
  output logic       validSamp_R14H,
  input  logic       credit_ret,
  input  logic       mode_req,
  input  logic [3:0] mode_new,
  output logic       mode_ack,
  output logic       mode_err,
  output logic [3:0] subSample_RnnnnU,
  output logic       pipe_empty
);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  state_t                state_q, state_d;
  logic [CRED_W-1:0]     cred_q;
  logic [PIPE_DEPTH-1:0] trk_q;
  logic [3:0]            mode_q;
  logic [3:0]            mode_lat_q;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  hold_q;
  logic                  issue;
  logic                  new_onehot;
  logic                  req_fresh;
  logic                  drain_done;
  logic                  ret_ok;

  assign new_onehot = (mode_new != '0) && ((mode_new & (mode_new - 4'd1)) == '0);
  // hold_q blocks a request that is still held after being answered, so each
  // request yields exactly one ack or err pulse.
  assign req_fresh  = mode_req & ~hold_q;
  // No issue happens in DRAIN, so once the tracker would shift out to zero on
  // this edge the pipe is empty in the next cycle and APPLY can start there.
  assign drain_done = ((trk_q << 1) == '0);
  assign ret_ok     = credit_ret & (cred_q != CRED_W'(CREDITS));

  assign samp_ready_out   = ~rst & (state_q == RUN) & ~mode_req & (cred_q != '0);
  assign issue            = samp_valid_in & samp_ready_out;
  assign validSamp_R14H   = issue;
  assign pipe_empty       = ~|trk_q & ~issue;
  assign mode_ack         = ack_q;
  assign mode_err         = err_q;
  assign subSample_RnnnnU = mode_q;

  // Next-state and one-cycle ack/err pulse decode
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (req_fresh) begin
          if (!new_onehot)            err_d   = 1'b1;
          else if (mode_new == mode_q) ack_d  = 1'b1;
          else                        state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = APPLY;
          ack_d   = 1'b1;
        end
      end
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State, pulse registers and request bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      mode_q     <= 4'b1000;
      mode_lat_q <= 4'b1000;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (!mode_req)
        hold_q <= 1'b0;
      else if (req_fresh && state_q == RUN)
        hold_q <= 1'b1;
      if (state_q == RUN && state_d == DRAIN)
        mode_lat_q <= mode_new;
      if (state_q == DRAIN && drain_done)
        mode_q <= mode_lat_q;
    end
  end

  // Downstream credit counter, saturating at CREDITS
  always_ff @(posedge clk) begin
    if (rst)
      cred_q <= CRED_W'(CREDITS);
    else if (issue && !credit_ret)
      cred_q <= cred_q - CRED_W'(1);
    else if (!issue && ret_ok)
      cred_q <= cred_q + CRED_W'(1);
  end

  // In-flight tracker for the hash pipeline
  always_ff @(posedge clk) begin
    if (rst)
      trk_q <= '0;
    else
      trk_q <= (trk_q << 1) | PIPE_DEPTH'(issue);
  end

  a_mode_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(subSample_RnnnnU));

endmodule

// File: tb/tb_hash_mode_ctrl.sv
// Testbench for hash_mode_ctrl: cycle-by-cycle vector table with expected
// outputs queued at drive time and compared mid-cycle.
module tb_hash_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       samp_valid_in;
  logic       samp_ready_out;
  logic       validSamp_R14H;
  logic       credit_ret;
  logic       mode_req;
  logic [3:0] mode_new;
  logic       mode_ack;
  logic       mode_err;
  logic [3:0] subSample_RnnnnU;
  logic       pipe_empty;

  hash_mode_ctrl #(.PIPE_DEPTH(3), .CREDITS(4), .CRED_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .samp_valid_in    (samp_valid_in),
    .samp_ready_out   (samp_ready_out),
    .validSamp_R14H   (validSamp_R14H),
    .credit_ret       (credit_ret),
    .mode_req         (mode_req),
    .mode_new         (mode_new),
    .mode_ack         (mode_ack),
    .mode_err         (mode_err),
    .subSample_RnnnnU (subSample_RnnnnU),
    .pipe_empty       (pipe_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic       c;
    logic       q;
    logic [3:0] m;
    logic       rdy;
    logic       iss;
    logic       ack;
    logic       err;
    logic [3:0] mode;
    logic       empty;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  function automatic void add(input logic r, v, c, q, input logic [3:0] m,
                              input logic rdy, iss, ack, err,
                              input logic [3:0] mode, input logic empty);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.q = q; t.m = m;
    t.rdy = rdy; t.iss = iss; t.ack = ack; t.err = err;
    t.mode = mode; t.empty = empty;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t t);
    vec_t e;
    @(posedge clk);
    #1;
    rst           = t.r;
    samp_valid_in = t.v;
    credit_ret    = t.c;
    mode_req      = t.q;
    mode_new      = t.m;
    sb.push_back(t);
    #5;
    e = sb.pop_front();
    chk("ready", {3'b0, samp_ready_out}, {3'b0, e.rdy});
    chk("issue", {3'b0, validSamp_R14H}, {3'b0, e.iss});
    chk("ack",   {3'b0, mode_ack},       {3'b0, e.ack});
    chk("err",   {3'b0, mode_err},       {3'b0, e.err});
    chk("mode",  subSample_RnnnnU,       e.mode);
    chk("empty", {3'b0, pipe_empty},     {3'b0, e.empty});
    row++;
  endtask

  task automatic step(input logic r, v, c, q, input logic [3:0] m,
                      input logic rdy, iss, ack, err,
                      input logic [3:0] mode, input logic empty);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.q = q; t.m = m;
    t.rdy = rdy; t.iss = iss; t.ack = ack; t.err = err;
    t.mode = mode; t.empty = empty;
    apply_vec(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; samp_valid_in = 1'b0; credit_ret = 1'b0;
    mode_req = 1'b0; mode_new = 4'b1000;

    //   r  v  c  q  m        rdy iss ack err mode     empty
    // reset cycle: ready low even with valid high
    add(1, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1);
    // four credits -> four back-to-back issues then stall
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1);
    // return at zero credits with valid: issue only on the following cycle
    add(0, 1, 1, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    // refill and over-return: count must saturate at 4
    add(0, 0, 1, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 0);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    // one credit, issue and return in the same cycle keep pace
    add(0, 0, 1, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 1, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 1, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 1, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    // restore all four credits
    add(0, 0, 1, 0, 4'b1000, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 0);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
    add(0, 0, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b1000, 1);
    // last issue at t-1, request 0100 at t: ack and new mode at t+3, issue at t+4
    add(0, 1, 0, 0, 4'b1000, 1, 1, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 1, 4'b0100, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 1, 4'b0100, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 1, 4'b0100, 0, 0, 0, 0, 4'b1000, 0);
    add(0, 1, 0, 1, 4'b0100, 0, 0, 1, 0, 4'b0100, 1);
    add(0, 1, 0, 0, 4'b0100, 1, 1, 0, 0, 4'b0100, 0);
    // not one-hot: single err pulse, mode kept, issue after req drops
    add(0, 1, 0, 1, 4'b0110, 0, 0, 0, 0, 4'b0100, 0);
    add(0, 1, 0, 1, 4'b0110, 0, 0, 0, 1, 4'b0100, 0);
    add(0, 1, 0, 1, 4'b0110, 0, 0, 0, 0, 4'b0100, 0);
    add(0, 1, 0, 0, 4'b0110, 1, 1, 0, 0, 4'b0100, 0);
    // same mode: ack on the next cycle without a drain
    add(0, 0, 0, 1, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);
    add(0, 0, 0, 1, 4'b0100, 0, 0, 1, 0, 4'b0100, 0);
    add(0, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0);
    add(0, 0, 1, 0, 4'b0100, 1, 0, 0, 0, 4'b0100, 1);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply_vec(tbl[i]);

    // reset asserted mid-drain: back to mode 1000, four credits, no late ack
    step(0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 4'b0100, 0);
    step(0, 0, 0, 1, 4'b0001, 0, 0, 0, 0, 4'b0100, 0);
    step(1, 0, 0, 1, 4'b0001, 0, 0, 0, 0, 4'b0100, 0);
    step(0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 4'b1000, 1);
    for (int unsigned k = 0; k < 4; k++)
      step(0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 4'b1000, 0);
    step(0, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 4'b1000, 0);
    step(0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 4'b1000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
